// File: rtl/t07_mmio_pkg.sv
// Shared types and encodings for the MMIO router: FSM states, decoded targets and
// the two-bit read/write/idle encodings used on the data and memory ports.
package t07_mmio_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic [2:0] {TGT_REG, TGT_TFT, TGT_DMEM, TGT_IMEM, TGT_NONE} target_t;

  localparam logic [1:0] RWI_INST  = 2'b00;
  localparam logic [1:0] RWI_WRITE = 2'b01;
  localparam logic [1:0] RWI_READ  = 2'b10;
  localparam logic [1:0] RWI_IDLE  = 2'b11;

  localparam logic PRIO_DATA  = 1'b0;
  localparam logic PRIO_FETCH = 1'b1;

endpackage

// File: rtl/t07_mmio_decode.sv
// Address/op decode: maps a granted request onto its slave region and says whether
// that kind of access is allowed there.
module t07_mmio_decode
  import t07_mmio_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int REG_LIMIT  = 1024,
  parameter int TFT_LIMIT  = 2048,
  parameter int DMEM_LIMIT = 8192,
  parameter int IMEM_BASE  = 8192
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              is_fetch,
  input  logic              is_write,
  output target_t           tgt,
  output logic              legal
);

  localparam logic [ADDR_W-1:0] REG_L  = ADDR_W'(REG_LIMIT);
  localparam logic [ADDR_W-1:0] TFT_L  = ADDR_W'(TFT_LIMIT);
  localparam logic [ADDR_W-1:0] DMEM_L = ADDR_W'(DMEM_LIMIT);
  localparam logic [ADDR_W-1:0] IMEM_B = ADDR_W'(IMEM_BASE);

  always_comb begin
    if (addr < REG_L)        tgt = TGT_REG;
    else if (addr < TFT_L)   tgt = TGT_TFT;
    else if (addr < DMEM_L)  tgt = TGT_DMEM;
    else if (addr >= IMEM_B) tgt = TGT_IMEM;
    else                     tgt = TGT_NONE;
  end

  // Fetches may only hit IMEM; data ports never may.
  always_comb begin
    legal = 1'b0;
    if (is_fetch) legal = (tgt == TGT_IMEM);
    else begin
      unique case (tgt)
        TGT_REG:  legal = !is_write;
        TGT_TFT:  legal = is_write;
        TGT_DMEM: legal = 1'b1;
        default:  legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/t07_mmio_router.sv
// MMIO router: round-robin between fetch and data ports, one outstanding strobe/ack
// transaction at a time, registered response with a one-cycle done pulse.
module t07_mmio_router
  import t07_mmio_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_LIMIT  = 1024,
  parameter int TFT_LIMIT  = 2048,
  parameter int DMEM_LIMIT = 8192,
  parameter int IMEM_BASE  = 8192,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_done,
  output logic              fetch_err,
  input  logic [1:0]        d_rwi,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              busy,
  output logic              reg_ri,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              tft_wi,
  output logic [ADDR_W-1:0] tft_addr,
  output logic [DATA_W-1:0] tft_wdata,
  input  logic              tft_ack,
  output logic [1:0]        mem_rwi,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_t            state_q, state_d;
  target_t           tgt_q, dec_tgt;
  logic              prio_q, fetch_q, write_q, err_q, dec_legal;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, sel_rdata;
  logic [CNT_W-1:0]  cnt_q;

  logic fetch_pend, d_pend, gnt_fetch, gnt_any, ack_sel, tmo_hit, mem_sel;
  logic [ADDR_W-1:0] addr_sel;

  assign fetch_pend = fetch_req;
  assign d_pend     = (d_rwi == RWI_WRITE) || (d_rwi == RWI_READ);
  assign gnt_fetch  = fetch_pend && (!d_pend || prio_q == PRIO_FETCH);
  assign gnt_any    = fetch_pend || d_pend;
  assign addr_sel   = gnt_fetch ? fetch_addr : d_addr;

  t07_mmio_decode #(
    .ADDR_W(ADDR_W), .REG_LIMIT(REG_LIMIT), .TFT_LIMIT(TFT_LIMIT),
    .DMEM_LIMIT(DMEM_LIMIT), .IMEM_BASE(IMEM_BASE)
  ) u_decode (
    .addr(addr_sel), .is_fetch(gnt_fetch), .is_write(d_rwi == RWI_WRITE),
    .tgt(dec_tgt), .legal(dec_legal)
  );

  always_comb begin
    ack_sel   = 1'b0;
    sel_rdata = '0;
    unique case (tgt_q)
      TGT_REG:  begin ack_sel = reg_ack; sel_rdata = reg_rdata; end
      TGT_TFT:  ack_sel = tft_ack;
      TGT_DMEM, TGT_IMEM: begin ack_sel = mem_ack; sel_rdata = mem_rdata; end
      default:  ack_sel = 1'b0;
    endcase
  end

  // cnt_q + 1 is the number of ACCESS cycles including the current one.
  assign tmo_hit = (TIMEOUT != 0) && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = dec_legal ? ACCESS : RESP;
      ACCESS:  if (ack_sel || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    reg_ri     = (state_q == ACCESS) && (tgt_q == TGT_REG);
    tft_wi     = (state_q == ACCESS) && (tgt_q == TGT_TFT);
    mem_sel    = (state_q == ACCESS) && (tgt_q == TGT_DMEM || tgt_q == TGT_IMEM);
    reg_addr   = reg_ri ? addr_q : '0;
    tft_addr   = tft_wi ? addr_q : '0;
    tft_wdata  = tft_wi ? wdata_q : '0;
    mem_addr   = mem_sel ? addr_q : '0;
    mem_wdata  = (mem_sel && write_q) ? wdata_q : '0;
    mem_rwi    = !mem_sel ? RWI_IDLE : fetch_q ? RWI_INST : write_q ? RWI_WRITE : RWI_READ;
    fetch_done = (state_q == RESP) && fetch_q;
    fetch_err  = fetch_done && err_q;
    d_done     = (state_q == RESP) && !fetch_q;
    d_err      = d_done && err_q;
  end

  // Response registers load on the edge into RESP so data is valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= PRIO_DATA;
      fetch_q    <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      tgt_q      <= TGT_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      fetch_data <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (gnt_any) begin
          fetch_q <= gnt_fetch;
          write_q <= !gnt_fetch && (d_rwi == RWI_WRITE);
          addr_q  <= addr_sel;
          wdata_q <= d_wdata;
          tgt_q   <= dec_tgt;
          err_q   <= !dec_legal;
          cnt_q   <= '0;
          // Priority only rotates when both ports actually contended.
          if (fetch_pend && d_pend) prio_q <= gnt_fetch ? PRIO_DATA : PRIO_FETCH;
          if (!dec_legal) begin
            if (gnt_fetch) fetch_data <= '0;
            else           d_rdata    <= '0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (ack_sel) begin
            if (fetch_q) fetch_data <= sel_rdata;
            else         d_rdata    <= write_q ? '0 : sel_rdata;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            if (fetch_q) fetch_data <= '0;
            else         d_rdata    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
